// File: rtl/odd_seq_checker_pkg.sv
// Shared encodings and the odd-sequence next-value rule for the odd counter checker.
package odd_seq_checker_pkg;

    typedef enum logic [1:0] {
        StAcq0  = 2'd0,
        StAcq1  = 2'd1,
        StTrack = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam logic [2:0] ODD_MIN          = 3'd1;
    localparam logic [2:0] ODD_MAX          = 3'd7;
    localparam logic [2:0] ODD_STEP         = 3'd2;
    localparam logic [7:0] DEFAULT_SIG_POLY = 8'h1D;

    typedef struct packed {
        dir_e       dir;
        logic [2:0] val;
    } pred_t;

    // Reverses at the end points instead of wrapping, so 7 never follows 1 and vice versa.
    function automatic pred_t next_pred(input logic [2:0] cur, input dir_e dir);
        pred_t res;
        res.dir = dir;
        res.val = cur;
        if (dir == DIR_UP) begin
            if (cur == ODD_MAX) begin
                res.val = cur - ODD_STEP;
                res.dir = DIR_DN;
            end else begin
                res.val = cur + ODD_STEP;
            end
        end else begin
            if (cur == ODD_MIN) begin
                res.val = cur + ODD_STEP;
                res.dir = DIR_UP;
            end else begin
                res.val = cur - ODD_STEP;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// Parallel-input MISR with load enable and synchronous clear (clear has priority).
module misr_reg #(
    parameter int unsigned           SIG_W    = 8,
    parameter logic [SIG_W-1:0]      SIG_POLY = SIG_W'(8'h1D)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/odd_seq_checker.sv
// Self-synchronising monitor for the odd up/down counter: locks onto 1,3,5,7,5,3,...,
// flags deviations and compacts matched samples into a MISR signature.
module odd_seq_checker
    import odd_seq_checker_pkg::*;
#(
    parameter int unsigned      SIG_W    = 8,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEFAULT_SIG_POLY),
    parameter int unsigned      ERRCNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clr,
    input  logic                p1,
    input  logic                p2,
    input  logic                p3,
    output logic                locked,
    output logic                mismatch,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic [SIG_W-1:0]    signature
);

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [2:0]          s_q, s_d;
    logic [2:0]          pred_q, pred_d;
    logic [2:0]          v0_q, v0_d;
    logic                mismatch_q, mismatch_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;
    logic                match;
    logic                clr_en;
    pred_t               nxt;

    // Like every other register, the clear only acts on enabled cycles.
    assign clr_en = enable & clr;
    assign s_d    = enable ? {p3, p2, p1} : s_q;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pred_d     = pred_q;
        v0_d       = v0_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        match      = 1'b0;
        nxt        = '{dir: dir_q, val: pred_q};

        if (enable) begin
            case (state_q)
                StAcq0: begin
                    if (s_q == ODD_MIN || s_q == ODD_MAX) begin
                        // End points fix the direction outright.
                        nxt     = next_pred(s_q, DIR_UP);
                        pred_d  = nxt.val;
                        dir_d   = nxt.dir;
                        state_d = StTrack;
                    end else if (s_q[0]) begin
                        v0_d    = s_q;
                        state_d = StAcq1;
                    end
                end
                StAcq1: begin
                    if (s_q == v0_q + ODD_STEP) begin
                        nxt     = next_pred(s_q, DIR_UP);
                        pred_d  = nxt.val;
                        dir_d   = nxt.dir;
                        state_d = StTrack;
                    end else if (s_q == v0_q - ODD_STEP) begin
                        nxt     = next_pred(s_q, DIR_DN);
                        pred_d  = nxt.val;
                        dir_d   = nxt.dir;
                        state_d = StTrack;
                    end else begin
                        state_d = StAcq0;
                    end
                end
                StTrack: begin
                    if (s_q == pred_q) begin
                        match  = 1'b1;
                        nxt    = next_pred(pred_q, dir_q);
                        pred_d = nxt.val;
                        dir_d  = nxt.dir;
                    end else begin
                        mismatch_d = 1'b1;
                        err_d      = 1'b1;
                        if (!(&cnt_q)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        state_d = StAcq0;
                    end
                end
                default: state_d = StAcq0;
            endcase
        end

        if (clr_en) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StAcq0;
            dir_q      <= DIR_UP;
            s_q        <= '0;
            pred_q     <= '0;
            v0_q       <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            s_q        <= s_d;
            pred_q     <= pred_d;
            v0_q       <= v0_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    misr_reg #(
        .SIG_W   (SIG_W),
        .SIG_POLY(SIG_POLY)
    ) u_misr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (match),
        .clr  (clr_en),
        .din  ({{(SIG_W-3){1'b0}}, s_q}),
        .sig  (signature)
    );

    assign locked   = (state_q == StTrack);
    assign mismatch = mismatch_q;
    assign err      = err_q;
    assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker with hand-computed expectations.
module tb_odd_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       clr;
    logic       p1, p2, p3;
    logic       locked;
    logic       mismatch;
    logic       err;
    logic [3:0] err_cnt;
    logic [7:0] signature;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    odd_seq_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clr      (clr),
        .p1       (p1),
        .p2       (p2),
        .p3       (p3),
        .locked   (locked),
        .mismatch (mismatch),
        .err      (err),
        .err_cnt  (err_cnt),
        .signature(signature)
    );

    // Drive s for one edge, return 1 time unit after it.
    task automatic cyc(input logic [2:0] v);
        p1 = v[0];
        p2 = v[1];
        p3 = v[2];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        clr    = 1'b0;
        {p3, p2, p1} = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({locked, mismatch, err, err_cnt, signature} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {locked, mismatch, err, err_cnt, signature});
        end
    endtask

    task automatic test_lock_up();
        logic [2:0] seq [8];
        logic [7:0] sig_exp [8];
        logic       lock_exp [8];
        seq      = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd5, 3'd3, 3'd1, 3'd3};
        sig_exp  = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h01, 8'h07, 8'h0D, 8'h1B};
        lock_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(seq[i]);
            checks++;
            if (locked !== lock_exp[i] || mismatch !== 1'b0 || signature !== sig_exp[i]) begin
                errors++;
                $display("FAIL lock_up step %0d: locked=%b mismatch=%b sig=%h, want %b 0 %h",
                         i, locked, mismatch, signature, lock_exp[i], sig_exp[i]);
            end
        end
    endtask

    task automatic test_mismatch_relock();
        do_reset();
        cyc(3'd1);
        cyc(3'd3);
        cyc(3'd4);
        cyc(3'd5);
        checks++;
        if ({mismatch, err, err_cnt, locked, signature} !== {1'b1, 1'b1, 4'd1, 1'b0, 8'h03}) begin
            errors++;
            $display("FAIL inject: mis=%b err=%b cnt=%0d lock=%b sig=%h, want 1 1 1 0 03",
                     mismatch, err, err_cnt, locked, signature);
        end
        cyc(3'd7);
        checks++;
        if (mismatch !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL acq1_after_mis: mis=%b lock=%b, want 0 0", mismatch, locked);
        end
        cyc(3'd5);
        checks++;
        if (locked !== 1'b1 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL relock: lock=%b mis=%b, want 1 0", locked, mismatch);
        end
        cyc(3'd3);
        checks++;
        if ({mismatch, err, err_cnt, signature} !== {1'b0, 1'b1, 4'd1, 8'h03}) begin
            errors++;
            $display("FAIL after_relock: mis=%b err=%b cnt=%0d sig=%h, want 0 1 1 03",
                     mismatch, err, err_cnt, signature);
        end
    endtask

    task automatic test_mid_stream();
        do_reset();
        cyc(3'd5);
        cyc(3'd3);
        cyc(3'd1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL dn_lock: locked=%b, want 1", locked);
        end
        cyc(3'd3);
        checks++;
        if ({mismatch, err, signature} !== {1'b0, 1'b0, 8'h01}) begin
            errors++;
            $display("FAIL dn_pred1: mis=%b err=%b sig=%h, want 0 0 01",
                     mismatch, err, signature);
        end
        do_reset();
        cyc(3'd5);
        cyc(3'd1);
        cyc(3'd0);
        cyc(3'd0);
        checks++;
        if ({locked, mismatch, err} !== 3'b000) begin
            errors++;
            $display("FAIL bad_acq1: lock=%b mis=%b err=%b, want 0 0 0", locked, mismatch, err);
        end
    endtask

    task automatic test_saturate_clr();
        int pulses;
        do_reset();
        cyc(3'd1);
        cyc(3'd3);
        cyc(3'd5);
        cyc(3'd0);
        cyc(3'd1);
        pulses = int'(mismatch);
        for (int i = 0; i < 19; i++) begin
            cyc(3'd0);
            cyc(3'd1);
            pulses += int'(mismatch);
        end
        checks++;
        if (pulses != 20 || err_cnt !== 4'hF || err !== 1'b1 || signature !== 8'h03) begin
            errors++;
            $display("FAIL saturate: pulses=%0d cnt=%h err=%b sig=%h, want 20 f 1 03",
                     pulses, err_cnt, err, signature);
        end
        cyc(3'd0);
        clr = 1'b1;
        cyc(3'd1);
        clr = 1'b0;
        checks++;
        if ({mismatch, err, err_cnt, signature, locked} !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL clr_vs_mis: mis=%b err=%b cnt=%h sig=%h lock=%b, want 1 0 0 00 0",
                     mismatch, err, err_cnt, signature, locked);
        end
    endtask

    task automatic test_enable_gap();
        do_reset();
        cyc(3'd1);
        cyc(3'd3);
        cyc(3'd5);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(3'd0);
            checks++;
            if ({locked, mismatch, err, err_cnt, signature} !== {1'b1, 1'b0, 1'b0, 4'd0, 8'h03}) begin
                errors++;
                $display("FAIL gap %0d: lock=%b mis=%b err=%b cnt=%h sig=%h, want 1 0 0 0 03",
                         i, locked, mismatch, err, err_cnt, signature);
            end
        end
        enable = 1'b1;
        cyc(3'd7);
        cyc(3'd5);
        checks++;
        if ({locked, mismatch, err, signature} !== {1'b1, 1'b0, 1'b0, 8'h01}) begin
            errors++;
            $display("FAIL after_gap: lock=%b mis=%b err=%b sig=%h, want 1 0 0 01",
                     locked, mismatch, err, signature);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(3'd1);
        cyc(3'd3);
        cyc(3'd4);
        cyc(3'd5);
        cyc(3'd7);
        cyc(3'd5);
        checks++;
        if (locked !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: lock=%b err=%b, want 1 1", locked, err);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, mismatch, err, err_cnt, signature} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset: got %b, want all zero",
                     {locked, mismatch, err, err_cnt, signature});
        end
        rst_n = 1'b1;
        cyc(3'd1);
        cyc(3'd3);
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_lock: lock=%b err=%b, want 1 0", locked, err);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        clr    = 1'b0;
        {p3, p2, p1} = 3'd0;
        test_reset();
        test_lock_up();
        test_mismatch_relock();
        test_mid_stream();
        test_saturate_clr();
        test_enable_gap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
